// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parameterised register file.
// Holds the clear-FSM state encoding used by reg_file_param.
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_NUM_RD  = 2;
  localparam int DEF_ZERO_R0 = 0;
  localparam int DEF_BYPASS  = 1;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Ports: clk, rst_n (sync, active-low), flush, set/clr requests, busy.
module reg_scoreboard #(
  parameter int DEPTH   = 8,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] busy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Set is applied after clear so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    if (flush)  busy_d = '0;
    if (ZERO_R0 != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/reg_file_param.sv
// Multi-read-port register file with clear sweep and busy scoreboard.
// Ports: clk, rst_n, clr, ready, we/wr_*, rd_addr/rd_data, rsv_*, busy.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int ZERO_R0 = DEF_ZERO_R0,
  parameter int BYPASS  = DEF_BYPASS,
  localparam int DEPTH  = 1 << ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  output logic                       ready,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [DEPTH-1:0]           busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok;
  logic              wr_kill;

  assign ready   = (state_q == IDLE);
  assign wr_ok   = we && ready;
  assign wr_kill = (ZERO_R0 != 0) && (wr_addr == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage has no reset; the post-reset sweep zeroes it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!ready)                 mem_q[ptr_q]   <= '0;
      else if (wr_ok && !wr_kill) mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin : rd_mux
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      rv = mem_q[ra];
      if ((BYPASS != 0) && wr_ok && (ra == wr_addr))
        rv = wr_data;
      if ((ZERO_R0 != 0) && (ra == '0))
        rv = '0;
      rd_data[k*DATA_W +: DATA_W] = rv;
    end
  end

  reg_scoreboard #(
    .DEPTH   (DEPTH),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (ready && clr),
    .set_en   (rsv_en && ready),
    .set_addr (rsv_addr),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default build plus a
// ZERO_R0=1 / BYPASS=0 build driven with the same stimulus.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst_n, clr, we, rsv_en;
  logic [2:0]  wr_addr, rsv_addr;
  logic [7:0]  wr_data;
  logic [5:0]  rd_addr;
  logic [15:0] rd0, rd1;
  logic        ready0, ready1;
  logic [7:0]  busy0, busy1;
  int          errors = 0;
  int          checks = 0;
  int          lows;

  always #5 clk = ~clk;

  reg_file_param u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready0),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd0),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy0)
  );

  reg_file_param #(.ZERO_R0(1), .BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready1),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_lows(output int n);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (ready0) break;
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 0; we = 0; rsv_en = 0;
    wr_addr = 0; wr_data = 0; rsv_addr = 0; rd_addr = 0;
    step(); step();
    checks++;
    if (busy0 !== 8'h00) begin
      errors++; $display("FAIL rst_busy got %h exp 00", busy0);
    end
    rst_n = 1'b1;
    #1;
    count_lows(lows);
    checks++;
    if (lows !== 8) begin
      errors++; $display("FAIL rst_sweep got %0d exp 8", lows);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = {3'(i), 3'(i)};
      #1;
      checks++;
      if (rd0 !== 16'h0000 || rd1 !== 16'h0000) begin
        errors++;
        $display("FAIL rst_r%0d got %h/%h exp 0", i, rd0, rd1);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1; wr_addr = 4; wr_data = 8'h5A; step();
    wr_addr = 2; wr_data = 8'h33; step();
    we = 0; rd_addr = {3'd4, 3'd2}; #1;
    checks++;
    if (rd0 !== 16'h5A33 || rd1 !== 16'h5A33) begin
      errors++;
      $display("FAIL wr_rd got %h/%h exp 5a33", rd0, rd1);
    end
  endtask

  task automatic test_bypass();
    we = 1; wr_addr = 3; wr_data = 8'h11; step();
    wr_data = 8'hC7; rd_addr = {3'd4, 3'd3}; #1;
    checks++;
    if (rd0 !== 16'h5AC7) begin
      errors++; $display("FAIL byp_on got %h exp 5ac7", rd0);
    end
    checks++;
    if (rd1 !== 16'h5A11) begin
      errors++; $display("FAIL byp_off got %h exp 5a11", rd1);
    end
    step(); we = 0; #1;
    checks++;
    if (rd0 !== 16'h5AC7 || rd1 !== 16'h5AC7) begin
      errors++;
      $display("FAIL byp_after got %h/%h exp 5ac7", rd0, rd1);
    end
  endtask

  task automatic test_zero();
    we = 1; wr_addr = 0; wr_data = 8'hFF; step();
    we = 0; rd_addr = {3'd0, 3'd0}; #1;
    checks++;
    if (rd1 !== 16'h0000) begin
      errors++; $display("FAIL zr0_rd got %h exp 0000", rd1);
    end
    checks++;
    if (rd0 !== 16'hFFFF) begin
      errors++; $display("FAIL r0_rd got %h exp ffff", rd0);
    end
    rsv_en = 1; rsv_addr = 0; step(); rsv_en = 0;
    checks++;
    if (busy1 !== 8'h00) begin
      errors++; $display("FAIL zr0_busy got %h exp 00", busy1);
    end
    checks++;
    if (busy0 !== 8'h01) begin
      errors++; $display("FAIL r0_busy got %h exp 01", busy0);
    end
    we = 1; wr_data = 8'h00; step(); we = 0;
    checks++;
    if (busy0 !== 8'h00) begin
      errors++; $display("FAIL r0_unbusy got %h exp 00", busy0);
    end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_addr = 5; step();
    checks++;
    if (busy0 !== 8'h20 || busy1 !== 8'h20) begin
      errors++; $display("FAIL sb_set got %h exp 20", busy0);
    end
    we = 1; wr_addr = 5; wr_data = 8'h77; step();
    checks++;
    if (busy0 !== 8'h20) begin
      errors++; $display("FAIL sb_same got %h exp 20", busy0);
    end
    rsv_en = 0; step();
    checks++;
    if (busy0 !== 8'h00) begin
      errors++; $display("FAIL sb_clr got %h exp 00", busy0);
    end
    we = 0; rsv_en = 1; rsv_addr = 6; step();
    we = 1; wr_addr = 6; rsv_addr = 1; step();
    checks++;
    if (busy0 !== 8'h02 || busy1 !== 8'h02) begin
      errors++; $display("FAIL sb_diff got %h exp 02", busy0);
    end
    rsv_en = 0; wr_addr = 1; step(); we = 0;
    checks++;
    if (busy0 !== 8'h00) begin
      errors++; $display("FAIL sb_empty got %h exp 00", busy0);
    end
  endtask

  task automatic test_clear();
    rsv_en = 1; rsv_addr = 7; step(); rsv_en = 0;
    checks++;
    if (busy0 !== 8'h80) begin
      errors++; $display("FAIL clr_pre got %h exp 80", busy0);
    end
    clr = 1; step(); clr = 0;
    we = 1; wr_addr = 4; wr_data = 8'hEE;
    rsv_en = 1; rsv_addr = 4;
    rd_addr = {3'd4, 3'd2}; #1;
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      if (ready0) break;
      lows++;
      if (c == 4) begin
        checks++;
        if (rd0 !== 16'h5A00 || busy0 !== 8'h00) begin
          errors++;
          $display("FAIL clr_mid got %h/%h exp 5a00/00",
                   rd0, busy0);
        end
      end
      clr = (c == 3);
      step();
    end
    clr = 0; we = 0; rsv_en = 0; #1;
    checks++;
    if (lows !== 8) begin
      errors++; $display("FAIL clr_len got %0d exp 8", lows);
    end
    checks++;
    if (rd0 !== 16'h0000 || busy0 !== 8'h00) begin
      errors++;
      $display("FAIL clr_end got %h/%h exp 0000/00", rd0, busy0);
    end
  endtask

  task automatic test_reset_mid_sweep();
    we = 1; wr_addr = 4; wr_data = 8'h5A; step(); we = 0;
    clr = 1; step(); clr = 0;
    repeat (5) step();
    checks++;
    if (ready0 !== 1'b0) begin
      errors++; $display("FAIL mid_busy got %b exp 0", ready0);
    end
    rst_n = 0; step(); rst_n = 1; #1;
    count_lows(lows);
    checks++;
    if (lows !== 8) begin
      errors++; $display("FAIL mid_rst got %0d exp 8", lows);
    end
    rd_addr = {3'd4, 3'd4}; #1;
    checks++;
    if (rd0 !== 16'h0000 || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_end got %h/%b exp 0000/1", rd0, ready1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_clear();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
